// File: rtl/fetch_queue_w.sv
// fetch_queue_w: parametrised bundle fetch stage with a circular fetch queue.
// Issues aligned FETCH_W-wide requests to a 1-cycle-latency instruction memory,
// buffers the responses in an FQ_DEPTH-entry queue and presents the head bundle
// to decode over a ready/valid handshake. Redirects flush everything in the
// same cycle and mask off the slots below a misaligned target.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   fetch_en           permit new instruction-memory requests
//   redirect_en/pc     flush and restart fetch at redirect_pc (bits [1:0] ignored)
//   imem_req/addr      request strobe (combinational) and aligned bundle address
//   imem_rdata         bundle data, valid one cycle after imem_req
//   dec_valid/pc/instr per-slot view of the head bundle (zero when empty)
//   dec_ready          decode accepts the head bundle
//   fq_count           number of bundles held in the queue
module fetch_queue_w #(
    parameter int unsigned    FETCH_W  = 2,
    parameter int unsigned    PC_W     = 32,
    parameter int unsigned    INSTR_W  = 32,
    parameter int unsigned    FQ_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         fetch_en,
    input  logic                         redirect_en,
    input  logic [PC_W-1:0]              redirect_pc,
    output logic                         imem_req,
    output logic [PC_W-1:0]              imem_addr,
    input  logic [FETCH_W*INSTR_W-1:0]   imem_rdata,
    output logic [FETCH_W-1:0]           dec_valid,
    output logic [FETCH_W*PC_W-1:0]      dec_pc,
    output logic [FETCH_W*INSTR_W-1:0]   dec_instr,
    input  logic                         dec_ready,
    output logic [$clog2(FQ_DEPTH):0]    fq_count
);

    localparam int unsigned CNT_W       = $clog2(FQ_DEPTH) + 1;
    localparam int unsigned PTR_W       = $clog2(FQ_DEPTH);
    localparam int unsigned ALIGN_BYTES = 4 * FETCH_W;
    localparam int unsigned OFF_W       = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;
    localparam int unsigned BUNDLE_W    = FETCH_W * INSTR_W;

    // Control state
    logic [PC_W-1:0]    r_pc;
    logic               r_inflight;
    logic [FETCH_W-1:0] r_if_mask;
    logic [PC_W-1:0]    r_if_base;
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;

    // Queue storage
    logic [FETCH_W-1:0]  r_q_mask [FQ_DEPTH];
    logic [PC_W-1:0]     r_q_base [FQ_DEPTH];
    logic [BUNDLE_W-1:0] r_q_data [FQ_DEPTH];

    logic [PC_W-1:0]    w_base;
    logic [OFF_W-1:0]   w_off;
    logic [FETCH_W-1:0] w_start_mask;
    logic               w_credit_ok;
    logic               w_req;
    logic               w_push;
    logic               w_pop;
    logic               w_nonempty;
    logic [FETCH_W-1:0] w_dec_valid;

    // Bundle base address and slot offset of the current fetch PC
    assign w_base = r_pc & ~PC_W'(ALIGN_BYTES - 1);
    assign w_off  = OFF_W'(r_pc >> 2) & OFF_W'(FETCH_W - 1);

    // Slots below the entry offset are invalid; zero offset gives a full mask
    always_comb begin
        w_start_mask = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            w_start_mask[i] = (OFF_W'(i) >= w_off);
        end
    end

    // Credits cover both queued bundles and the one still in the memory pipe
    assign w_credit_ok = (r_count + CNT_W'(r_inflight)) < CNT_W'(FQ_DEPTH);
    assign w_req       = fetch_en && !redirect_en && !reset && w_credit_ok;

    assign w_nonempty  = (r_count != '0);
    assign w_dec_valid = w_nonempty ? r_q_mask[r_head] : '0;
    assign w_push      = r_inflight && !redirect_en;
    assign w_pop       = (w_dec_valid != '0) && dec_ready && !redirect_en;

    // Control: fetch PC, inflight tracking, queue pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_inflight <= 1'b0;
            r_if_mask  <= '1;
            r_if_base  <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else if (redirect_en) begin
            r_pc       <= redirect_pc & ~PC_W'(3);
            r_inflight <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= w_req;
            if (w_req) begin
                r_if_mask <= w_start_mask;
                r_if_base <= w_base;
                r_pc      <= w_base + PC_W'(ALIGN_BYTES);
            end
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue entries need no reset: the empty check gates them from the outputs
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_mask[r_tail] <= r_if_mask;
            r_q_base[r_tail] <= r_if_base;
            r_q_data[r_tail] <= imem_rdata;
        end
    end

    // Head bundle view; slot PCs are derived from the stored base
    always_comb begin
        dec_pc = '0;
        if (w_nonempty) begin
            for (int i = 0; i < FETCH_W; i++) begin
                dec_pc[i*PC_W +: PC_W] = r_q_base[r_head] + PC_W'(4 * i);
            end
        end
    end

    assign dec_instr = w_nonempty ? r_q_data[r_head] : '0;
    assign dec_valid = w_dec_valid;
    assign imem_req  = w_req;
    assign imem_addr = w_base;
    assign fq_count  = r_count;

    // The credit scheme must never let a response land in a full queue
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(w_push && (r_count == CNT_W'(FQ_DEPTH))));

endmodule
